// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result decoder and its match helper.
//   op_e        : ALU operation codes in rotation order (sum..shr)
//   NUM_OPS     : number of ALU operations
//   dec_state_e : decoder FSM states
//   next_op()   : successor of an op in the rotation, wrapping shr -> sum
package alu_pkg;

  typedef enum logic [2:0] {
    OP_SUM = 3'd0,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_SHL,
    OP_SHR
  } op_e;

  localparam int NUM_OPS = 6;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_ACQUIRE,
    ST_LOCKED
  } dec_state_e;

  function automatic op_e next_op(input op_e op);
    return (op == OP_SHR) ? OP_SUM : op_e'(op + 3'd1);
  endfunction

endpackage

// File: rtl/alu_match.sv
// Combinational match mask: bit i is set when r equals ALU op i applied to a,b.
// Reusable by a scoreboard.
//   a, b : ALU operands
//   r    : observed ALU result
//   mask : one bit per op_e value
module alu_match
  import alu_pkg::*;
(
  input  logic [7:0]         a,
  input  logic [7:0]         b,
  input  logic [7:0]         r,
  output logic [NUM_OPS-1:0] mask
);

  logic [7:0] sum;
  logic [7:0] diff;

  // Explicit 8-bit intermediates give the mod-256 wrap.
  assign sum  = a + b;
  assign diff = a - b;

  assign mask[OP_SUM] = (r == sum);
  assign mask[OP_SUB] = (r == diff);
  assign mask[OP_AND] = (r == (a & b));
  assign mask[OP_OR]  = (r == (a | b));
  assign mask[OP_SHL] = (r == {a[6:0], 1'b0});
  assign mask[OP_SHR] = (r == {1'b0, a[7:1]});

endmodule

// File: rtl/alu_result_decoder.sv
// Passive observer of the auto-stepping ALU output bus. Decodes which op
// produced r, locks onto the sum->sub->and->or->shl->shr rotation, and flags
// sequence and step-period errors.
//
// Optional feature macro: ALU_DEC_PERIOD_CHECK_EN enables the period counter,
// the per-step period check and the lock timeout. Without it err_period is 0.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   a, b, r       : ALU operands and result, sampled when in_valid is high
//   op_out        : decoded op code
//   op_valid      : op_out meaningful (ACQUIRE or LOCKED)
//   locked        : decoder is LOCKED
//   step_pulse    : one cycle per accepted op step
//   err_seq       : result matched neither current nor next op
//   err_period    : step outside PERIOD+-TOL, or lock timeout
//   err_count     : saturating count of error cycles
// Decisions are registered on the sampling edge and presented on the outputs
// one edge later.
module alu_result_decoder
  import alu_pkg::*;
#(
  parameter int PERIOD = 100_000_000,
  parameter int TOL    = 16,
  parameter int CNT_W  = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] r,
  input  logic       in_valid,
  output logic [2:0] op_out,
  output logic       op_valid,
  output logic       locked,
  output logic       step_pulse,
  output logic       err_seq,
  output logic       err_period,
  output logic [7:0] err_count
);

  logic [NUM_OPS-1:0] mask;
  dec_state_e         state_q, state_d;
  op_e                cur_op_q, cur_op_d, nxt_op, hunt_op;
  logic               step_q, step_d;
  logic               seq_q, seq_d;
  logic               per_q, per_d;
  logic               clr_cnt;

  alu_match u_match (
    .a    (a),
    .b    (b),
    .r    (r),
    .mask (mask)
  );

  assign nxt_op = next_op(cur_op_q);

  always_comb begin
    hunt_op = OP_SUM;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (mask[i]) hunt_op = op_e'(i[2:0]);
    end
  end

`ifdef ALU_DEC_PERIOD_CHECK_EN
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(PERIOD - TOL);
  localparam logic [CNT_W-1:0] MAX_P = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0] TMO_P = CNT_W'(PERIOD + TOL + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] elapsed;

  // cnt_q holds edges since the last commit minus one, so elapsed is the
  // period as seen on the edge being evaluated.
  assign elapsed = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst)                       cnt_q <= '0;
    else if (clr_cnt)              cnt_q <= '0;
    else if (state_q == ST_LOCKED) cnt_q <= elapsed;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(PERIOD), 32'(TOL), 32'(CNT_W)};
`endif

  // NOTE: every combinational output is defaulted first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cur_op_d = cur_op_q;
    step_d   = 1'b0;
    seq_d    = 1'b0;
    per_d    = 1'b0;
    clr_cnt  = 1'b0;

    if (in_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if ($onehot(mask)) begin
            cur_op_d = hunt_op;
            state_d  = ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (mask[cur_op_q]) begin
            state_d = ST_ACQUIRE;
          end else if (mask[nxt_op]) begin
            cur_op_d = nxt_op;
            clr_cnt  = 1'b1;
            state_d  = ST_LOCKED;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          // Current op wins over next when both match.
          if (mask[cur_op_q]) begin
            state_d = ST_LOCKED;
          end else if (mask[nxt_op]) begin
            cur_op_d = nxt_op;
            step_d   = 1'b1;
            clr_cnt  = 1'b1;
`ifdef ALU_DEC_PERIOD_CHECK_EN
            per_d    = (elapsed < MIN_P) || (elapsed > MAX_P);
`endif
          end else begin
            seq_d   = 1'b1;
            state_d = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

`ifdef ALU_DEC_PERIOD_CHECK_EN
    // Timeout runs regardless of in_valid; a step or sequence error on the
    // same edge takes precedence.
    if (state_q == ST_LOCKED && !step_d && !seq_d && elapsed >= TMO_P) begin
      per_d   = 1'b1;
      state_d = ST_HUNT;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_HUNT;
      cur_op_q <= OP_SUM;
      step_q   <= 1'b0;
      seq_q    <= 1'b0;
      per_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_op_q <= cur_op_d;
      step_q   <= step_d;
      seq_q    <= seq_d;
      per_q    <= per_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_out     <= 3'd0;
      op_valid   <= 1'b0;
      locked     <= 1'b0;
      step_pulse <= 1'b0;
      err_seq    <= 1'b0;
      err_period <= 1'b0;
      err_count  <= 8'd0;
    end else begin
      op_out     <= cur_op_q;
      op_valid   <= (state_q != ST_HUNT);
      locked     <= (state_q == ST_LOCKED);
      step_pulse <= step_q;
      err_seq    <= seq_q;
      err_period <= per_q;
      if ((seq_q || per_q) && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_result_decoder.sv
// Self-checking bench for alu_result_decoder with PERIOD=10, TOL=1.
// Segments of held inputs are applied from a table; after each segment the
// steady outputs and the pulse totals since the last reset are compared.
module tb_alu_result_decoder;

`ifdef ALU_DEC_PERIOD_CHECK_EN
  localparam bit PC = 1'b1;
`else
  localparam bit PC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = 8'd0, b = 8'd0, r = 8'd0;
  logic       in_valid = 1'b0;
  logic [2:0] op_out;
  logic       op_valid, locked, step_pulse, err_seq, err_period;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;
  int n_step = 0, n_seq = 0, n_per = 0;
  int b_step = 0, b_seq = 0, b_per = 0;

  alu_result_decoder #(.PERIOD(10), .TOL(1), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .r          (r),
    .in_valid   (in_valid),
    .op_out     (op_out),
    .op_valid   (op_valid),
    .locked     (locked),
    .step_pulse (step_pulse),
    .err_seq    (err_seq),
    .err_period (err_period),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (step_pulse) n_step++;
    if (err_seq)    n_seq++;
    if (err_period) n_per++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         do_rst;
    logic [7:0] a, b, r;
    bit         v;
    int         n;
    bit         chk;
    int         op, valid, lck, steps, seqs, pers, ecnt;
  } seg_t;

  seg_t tbl[$];

  function automatic seg_t mk(bit do_rst, logic [7:0] a_i, logic [7:0] b_i,
                              logic [7:0] r_i, bit v, int n, bit chk,
                              int op, int valid, int lck, int steps,
                              int seqs, int pers, int ecnt);
    seg_t s;
    s.do_rst = do_rst; s.a = a_i; s.b = b_i; s.r = r_i; s.v = v; s.n = n;
    s.chk = chk; s.op = op; s.valid = valid; s.lck = lck; s.steps = steps;
    s.seqs = seqs; s.pers = pers; s.ecnt = ecnt;
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a_i, input logic [7:0] b_i,
                       input logic [7:0] r_i, input bit v);
    a = a_i; b = b_i; r = r_i; in_valid = v;
  endtask

  // Reset with live bus activity; everything must read zero.
  task automatic do_reset();
    rst = 1'b1;
    drive(8'h12, 8'h05, 8'h0D, 1'b1);
    repeat (2) @(negedge clk);
    check("rst op_out", op_out, 0);
    check("rst op_valid", op_valid, 0);
    check("rst locked", locked, 0);
    check("rst step_pulse", step_pulse, 0);
    check("rst err_seq", err_seq, 0);
    check("rst err_period", err_period, 0);
    check("rst err_count", err_count, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("post-rst op_valid", op_valid, 0);
    b_step = n_step; b_seq = n_seq; b_per = n_per;
  endtask

  // One sequence error per call-iteration: HUNT->ACQ(shr)->LOCKED(sum)->err.
  task automatic seq_err_burst(input int k);
    for (int i = 0; i < k; i++) begin
      drive(8'hF0, 8'h0F, 8'h78, 1'b1); @(negedge clk);
      drive(8'hF0, 8'h0F, 8'hFF, 1'b1); @(negedge clk);
      drive(8'hF0, 8'h0F, 8'h00, 1'b1); @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Clean lock-on, a=0x12 b=0x05: 0x17 is sum|or ambiguous, 0x0D is sub.
    tbl.push_back(mk(1, 8'h12, 8'h05, 8'h17, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h12, 8'h05, 8'h0D, 1, 10, 1, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h12, 8'h05, 8'h00, 1, 10, 1, 2, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h12, 8'h05, 8'h17, 1, 10, 1, 3, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 8'h12, 8'h05, 8'h24, 1, 10, 1, 4, 1, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 8'h12, 8'h05, 8'h09, 1, 10, 1, 5, 1, 1, 3, 0, 0, 0));
    tbl.push_back(mk(0, 8'h12, 8'h05, 8'h17, 1, 10, 1, 0, 1, 1, 4, 0, 0, 0));
    tbl.push_back(mk(0, 8'h12, 8'h05, 8'h0D, 1,  8, 1, 1, 1, 1, 5, 0, 0, 0));
    // Step after only 8 cycles, then starve the bus past PERIOD+TOL.
    tbl.push_back(mk(0, 8'h12, 8'h05, 8'h00, 1,  3, 1, 2, 1, 1, 6, 0,
                     PC ? 1 : 0, PC ? 1 : 0));
    tbl.push_back(mk(0, 8'h12, 8'h05, 8'h00, 0, 14, 1, 2, PC ? 0 : 1, PC ? 0 : 1,
                     6, 0, PC ? 2 : 0, PC ? 2 : 0));
    // Ambiguity: all-zero matches every op; 0x81 is sum|or; 0x40 only shr.
    tbl.push_back(mk(1, 8'h00, 8'h00, 8'h00, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h80, 8'h01, 8'h81, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h80, 8'h01, 8'h40, 1, 5, 1, 5, 1, 0, 0, 0, 0, 0));
    // Sequence error while LOCKED on sum: r = a&b is neither sum nor sub.
    tbl.push_back(mk(1, 8'hF0, 8'h0F, 8'h78, 1, 3, 1, 5, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'hF0, 8'h0F, 8'hFF, 1, 3, 1, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'hF0, 8'h0F, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'hF0, 8'h0F, 8'h00, 0, 4, 1, 0, 0, 0, 0, 1, 0, 1));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].do_rst) do_reset();
      drive(tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].v);
      repeat (tbl[i].n) @(negedge clk);
      if (tbl[i].chk) begin
        check($sformatf("seg%0d op_out", i), op_out, tbl[i].op);
        check($sformatf("seg%0d op_valid", i), op_valid, tbl[i].valid);
        check($sformatf("seg%0d locked", i), locked, tbl[i].lck);
        check($sformatf("seg%0d steps", i), n_step - b_step, tbl[i].steps);
        check($sformatf("seg%0d err_seq pulses", i), n_seq - b_seq, tbl[i].seqs);
        check($sformatf("seg%0d err_period pulses", i), n_per - b_per, tbl[i].pers);
        check($sformatf("seg%0d err_count", i), err_count, tbl[i].ecnt);
      end
    end

    // Error counter saturation.
    do_reset();
    seq_err_burst(254);
    check("sat err_count 254", err_count, 254);
    seq_err_burst(1);
    check("sat err_count 255", err_count, 255);
    seq_err_burst(45);
    check("sat err_count hold", err_count, 255);
    check("sat err_seq pulses", n_seq - b_seq, 300);
    check("sat locked", locked, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
